// File: rtl/debug_scan_ctrl.sv
// debug_scan_ctrl: drives single steps of a core in debug mode and dumps
// NUM_WORDS debug words as a byte frame (0xA5 header, data MSB first,
// XOR checksum of the data bytes) over a valid/ready byte stream.
module debug_scan_ctrl #(
    parameter int NUM_WORDS = 64,
    parameter int STEP_HALF = 4,
    parameter int SETTLE    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_mode,
    input  logic        step_req,
    input  logic        start,
    output logic        debug_en,
    output logic        debug_step,
    output logic [6:0]  debug_addr,
    input  logic [31:0] debug_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE, STEP_HI, STEP_LO, HDR, SETTLE_W, CAPTURE, SEND, CHK
    } state_t;

    localparam logic [6:0]  ADDR_LAST   = 7'(NUM_WORDS - 1);
    localparam logic [15:0] STEP_LAST   = 16'(STEP_HALF - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [7:0]  HDR_BYTE    = 8'hA5;

    state_t      r_state;
    logic        r_den;
    logic        r_step;
    logic [6:0]  r_addr;
    logic [31:0] r_shift;     // tx_data is always the top byte of this register
    logic        r_txv;
    logic        r_busy;
    logic        r_done;
    logic        r_pend;
    logic [7:0]  r_csum;
    logic [1:0]  r_bcnt;
    logic [15:0] r_cnt;

    logic        w_step_ok;
    logic        w_pend;
    state_t      w_settle_state;

    // A step is only honoured while the core is held in debug mode.
    assign w_step_ok = r_den & step_req;
    // A start arriving in the same cycle as the pending check counts too.
    assign w_pend    = r_pend | start;
    // With no settle time the capture follows the address change directly.
    assign w_settle_state = (SETTLE == 0) ? CAPTURE : SETTLE_W;

    assign debug_en   = r_den;
    assign debug_step = r_step;
    assign debug_addr = r_addr;
    assign tx_data    = r_shift[31:24];
    assign tx_valid   = r_txv;
    assign busy       = r_busy;
    assign frame_done = r_done;

    // Debug enable is the inverted run mode, delayed by one register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_den <= 1'b0;
        end else begin
            r_den <= ~run_mode;
        end
    end

    // Main controller: step pulse generation, frame sequencing, byte handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_step  <= 1'b0;
            r_addr  <= 7'd0;
            r_shift <= 32'd0;
            r_txv   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pend  <= 1'b0;
            r_csum  <= 8'd0;
            r_bcnt  <= 2'd0;
            r_cnt   <= 16'd0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_pend <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_step_ok) begin
                        // Step wins; a pending start is serviced after STEP_LO.
                        r_state <= STEP_HI;
                        r_step  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= STEP_LAST;
                    end else if (w_pend) begin
                        r_state <= HDR;
                        r_pend  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_addr  <= 7'd0;
                        r_csum  <= 8'd0;
                        r_shift <= {HDR_BYTE, 24'd0};
                        r_txv   <= 1'b1;
                    end
                end
                STEP_HI: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= STEP_LO;
                        r_step  <= 1'b0;
                        r_cnt   <= STEP_LAST;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                STEP_LO: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (w_pend) begin
                        // Go straight into the dump without passing IDLE.
                        r_state <= HDR;
                        r_pend  <= 1'b0;
                        r_addr  <= 7'd0;
                        r_csum  <= 8'd0;
                        r_shift <= {HDR_BYTE, 24'd0};
                        r_txv   <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                HDR: begin
                    if (tx_ready) begin
                        r_txv   <= 1'b0;
                        r_state <= w_settle_state;
                        r_cnt   <= SETTLE_LAST;
                    end
                end
                SETTLE_W: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                CAPTURE: begin
                    r_shift <= debug_data;
                    r_txv   <= 1'b1;
                    r_bcnt  <= 2'd0;
                    r_state <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        r_csum <= r_csum ^ r_shift[31:24];
                        if (r_bcnt != 2'd3) begin
                            r_bcnt  <= r_bcnt + 2'd1;
                            r_shift <= {r_shift[23:0], 8'd0};
                        end else if (r_addr == ADDR_LAST) begin
                            // Checksum byte includes the byte accepted right now.
                            r_shift <= {r_csum ^ r_shift[31:24], 24'd0};
                            r_state <= CHK;
                        end else begin
                            r_addr  <= r_addr + 7'd1;
                            r_txv   <= 1'b0;
                            r_state <= w_settle_state;
                            r_cnt   <= SETTLE_LAST;
                        end
                    end
                end
                CHK: begin
                    if (tx_ready) begin
                        r_txv   <= 1'b0;
                        r_shift <= 32'd0;
                        r_done  <= 1'b1;
                        r_addr  <= 7'd0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_txv   <= 1'b0;
                    r_step  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_scan_ctrl.sv
// Testbench for debug_scan_ctrl: randomized core contents, ready patterns and
// mode changes, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_debug_scan_ctrl;

    localparam int NW = 64;
    localparam int SH = 4;
    localparam int ST = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_mode;
    logic        step_req;
    logic        start;
    logic        debug_en;
    logic        debug_step;
    logic [6:0]  debug_addr;
    logic [31:0] debug_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;

    // Stub core: read data is a combinational lookup of the debug address.
    logic [31:0] core_mem [0:127];
    assign debug_data = core_mem[debug_addr];

    always #5 clk = ~clk;

    debug_scan_ctrl #(.NUM_WORDS(NW), .STEP_HALF(SH), .SETTLE(ST)) dut (
        .clk        (clk),
        .rst        (rst),
        .run_mode   (run_mode),
        .step_req   (step_req),
        .start      (start),
        .debug_en   (debug_en),
        .debug_step (debug_step),
        .debug_addr (debug_addr),
        .debug_data (debug_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    int   cyc, fd_cnt, step_hi_cnt, busy_cnt, busy_fall;
    int   hold_err, den_err, addr_err, first_fd_cyc;
    logic prev_stall, prev_busy, prev_rm, have_prev;
    logic [7:0] prev_data;

    task automatic clear_mon();
        rxq.delete();
        cyc = 0; fd_cnt = 0; step_hi_cnt = 0; busy_cnt = 0; busy_fall = 0;
        hold_err = 0; den_err = 0; addr_err = 0; first_fd_cyc = -1;
        prev_stall = 1'b0; prev_busy = busy; have_prev = 1'b0; prev_rm = run_mode;
        prev_data = 8'd0;
    endtask

    // Observe the current cycle (inputs already driven), then advance one clock.
    task automatic tick();
        if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) hold_err++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (have_prev && debug_en !== ~prev_rm) den_err++;
        prev_rm   = run_mode;
        have_prev = 1'b1;
        if (debug_addr > 7'(NW - 1)) addr_err++;
        if (tx_valid && tx_ready) rxq.push_back(tx_data);
        if (debug_step) step_hi_cnt++;
        if (busy) busy_cnt++;
        if (prev_busy && !busy) busy_fall++;
        prev_busy = busy;
        if (frame_done) begin
            if (fd_cnt == 0) first_fd_cyc = cyc;
            fd_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference frame(s): header, every word MSB first, XOR of the data bytes.
    task automatic model_frames(input int nf);
        logic [7:0] cs;
        logic [7:0] v;
        expq.delete();
        for (int f = 0; f < nf; f++) begin
            expq.push_back(8'hA5);
            cs = 8'd0;
            for (int a = 0; a < NW; a++) begin
                for (int b = 3; b >= 0; b--) begin
                    v = core_mem[a][8*b +: 8];
                    expq.push_back(v);
                    cs = cs ^ v;
                end
            end
            expq.push_back(cs);
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 128; a++) core_mem[a] = $urandom();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_tests++; if (debug_en !== 1'b0) begin n_fail++; $display("FAIL reset_debug_en got=%b want=0", debug_en); end
        n_tests++; if (debug_step !== 1'b0) begin n_fail++; $display("FAIL reset_debug_step got=%b want=0", debug_step); end
        n_tests++; if (debug_addr !== 7'd0) begin n_fail++; $display("FAIL reset_debug_addr got=%0d want=0", debug_addr); end
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset got valid=%b busy=%b want 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_frame_basic();
        logic [6:0]  a7;
        logic [7:0]  xs;
        logic [31:0] w5;
        int mism;
        for (int a = 0; a < 128; a++) begin
            a7 = 7'(a);
            core_mem[a] = {4{1'b0, a7}};
        end
        run_mode = 1'b1; tx_ready = 1'b1;
        model_frames(1);
        clear_mon();
        start = 1'b1; tick(); start = 1'b0;
        while (fd_cnt < 1 && cyc < 3000) tick();
        tick(); tick();
        n_tests++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL basic_frame_done got=%0d want=1", fd_cnt); end
        n_tests++; if (rxq.size() !== 4*NW+2) begin n_fail++; $display("FAIL basic_len got=%0d want=%0d", rxq.size(), 4*NW+2); end
        n_tests++;
        if (rxq.size() < 1 || rxq[0] !== 8'hA5) begin
            n_fail++; $display("FAIL basic_header got=%h want=a5", (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        w5 = (rxq.size() >= 25) ? {rxq[21], rxq[22], rxq[23], rxq[24]} : 32'hxxxxxxxx;
        n_tests++; if (w5 !== 32'h05050505) begin n_fail++; $display("FAIL basic_addr5 got=%h want=05050505", w5); end
        xs = 8'd0;
        for (int i = 1; i < rxq.size() - 1; i++) xs = xs ^ rxq[i];
        n_tests++;
        if (rxq.size() < 2 || rxq[rxq.size()-1] !== xs) begin
            n_fail++; $display("FAIL basic_checksum got=%h want=%h", (rxq.size() > 0) ? rxq[rxq.size()-1] : 8'hxx, xs);
        end
        mism = 0;
        for (int i = 0; i < rxq.size() && i < expq.size(); i++) if (rxq[i] !== expq[i]) mism++;
        n_tests++;
        if (mism != 0 || rxq.size() != expq.size()) begin
            n_fail++; $display("FAIL basic_sequence got mismatches=%0d len=%0d want 0 len=%0d", mism, rxq.size(), expq.size());
        end
        n_tests++;
        if (busy !== 1'b0 || debug_addr !== 7'd0 || addr_err !== 0) begin
            n_fail++; $display("FAIL basic_end_state got busy=%b addr=%0d addr_err=%0d want 0 0 0", busy, debug_addr, addr_err);
        end
    endtask

    task automatic test_frame_random_ready();
        int mism;
        fill_random();
        model_frames(1);
        tx_ready = 1'b1; step_req = 1'b0;
        clear_mon();
        start = 1'b1; tick(); start = 1'b0;
        while (fd_cnt < 1 && cyc < 4000) begin
            tx_ready = 1'($urandom_range(0, 1));
            run_mode = 1'($urandom_range(0, 1));
            step_req = ($urandom_range(0, 4) == 0);
            tick();
        end
        step_req = 1'b0; run_mode = 1'b1; tx_ready = 1'b1;
        n_tests++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL rnd_frame_done got=%0d want=1", fd_cnt); end
        mism = 0;
        for (int i = 0; i < rxq.size() && i < expq.size(); i++) if (rxq[i] !== expq[i]) mism++;
        n_tests++;
        if (mism != 0 || rxq.size() != expq.size()) begin
            n_fail++; $display("FAIL rnd_sequence got mismatches=%0d len=%0d want 0 len=%0d", mism, rxq.size(), expq.size());
        end
        n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL rnd_hold_stable got=%0d want=0", hold_err); end
        n_tests++; if (den_err !== 0) begin n_fail++; $display("FAIL rnd_debug_en_follow got=%0d want=0", den_err); end
        n_tests++; if (step_hi_cnt !== 0) begin n_fail++; $display("FAIL rnd_step_dropped got=%0d want=0", step_hi_cnt); end
        n_tests++; if (addr_err !== 0) begin n_fail++; $display("FAIL rnd_addr_range got=%0d want=0", addr_err); end
        tick(); tick(); tick();
    endtask

    task automatic test_step();
        logic st [0:11];
        logic bz [0:11];
        int mst, mbz;
        run_mode = 1'b0; tick(); tick();
        step_req = 1'b1; tick(); step_req = 1'b0;
        clear_mon();
        for (int i = 0; i < 12; i++) begin
            st[i] = debug_step;
            bz[i] = busy;
            step_req = (i == 2);
            tick();
        end
        step_req = 1'b0;
        mst = 0; mbz = 0;
        for (int i = 0; i < 12; i++) begin
            if (st[i] !== (i < SH)) mst++;
            if (bz[i] !== (i < 2*SH)) mbz++;
        end
        n_tests++; if (mst !== 0) begin n_fail++; $display("FAIL step_pulse_shape got mismatches=%0d want=0", mst); end
        n_tests++; if (mbz !== 0) begin n_fail++; $display("FAIL step_busy_8 got mismatches=%0d busy_cnt=%0d want 0 8", mbz, busy_cnt); end
        run_mode = 1'b1; tick(); tick();
        clear_mon();
        step_req = 1'b1; tick(); step_req = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        n_tests++; if (step_hi_cnt !== 0) begin n_fail++; $display("FAIL step_run_mode_step got=%0d want=0", step_hi_cnt); end
        n_tests++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL step_run_mode_busy got=%0d want=0", busy_cnt); end
    endtask

    task automatic test_back_to_back();
        int first_step, first_valid, second_acc, mism;
        bit sent2;
        fill_random();
        model_frames(2);
        run_mode = 1'b0; tx_ready = 1'b1; tick(); tick();
        clear_mon();
        start = 1'b1; step_req = 1'b1; tick(); start = 1'b0; step_req = 1'b0;
        first_step = -1; first_valid = -1; second_acc = -1; sent2 = 1'b0;
        while (fd_cnt < 2 && cyc < 6000) begin
            if (debug_step && first_step < 0) first_step = cyc;
            if (tx_valid && first_valid < 0) first_valid = cyc;
            if (!sent2 && rxq.size() >= 50) begin start = 1'b1; sent2 = 1'b1; end
            else start = 1'b0;
            tx_ready = 1'b1;
            if (rxq.size() == 4*NW+2 && second_acc < 0 && tx_valid) second_acc = cyc;
            tick();
        end
        start = 1'b0; run_mode = 1'b1;
        n_tests++; if (step_hi_cnt !== SH) begin n_fail++; $display("FAIL b2b_step_len got=%0d want=%0d", step_hi_cnt, SH); end
        n_tests++;
        if (first_step < 0 || first_valid - first_step !== 2*SH) begin
            n_fail++; $display("FAIL b2b_header_after_step got=%0d want=%0d", first_valid - first_step, 2*SH);
        end
        n_tests++; if (fd_cnt !== 2) begin n_fail++; $display("FAIL b2b_frame_done got=%0d want=2", fd_cnt); end
        n_tests++; if (busy_fall !== 2) begin n_fail++; $display("FAIL b2b_busy_falls got=%0d want=2", busy_fall); end
        n_tests++;
        if (second_acc < 0 || first_fd_cyc < 0 || second_acc - first_fd_cyc > 2 || second_acc <= first_fd_cyc) begin
            n_fail++; $display("FAIL b2b_second_gap got=%0d want 1..2", second_acc - first_fd_cyc);
        end
        mism = 0;
        for (int i = 0; i < rxq.size() && i < expq.size(); i++) if (rxq[i] !== expq[i]) mism++;
        n_tests++;
        if (mism != 0 || rxq.size() != expq.size()) begin
            n_fail++; $display("FAIL b2b_sequence got mismatches=%0d len=%0d want 0 len=%0d", mism, rxq.size(), expq.size());
        end
        tick(); tick();
    endtask

    task automatic test_reset_midframe();
        int mism;
        logic [22:0] outs;
        fill_random();
        run_mode = 1'b1; tx_ready = 1'b1;
        clear_mon();
        start = 1'b1; tick(); start = 1'b0;
        while (rxq.size() < 100 && cyc < 3000) tick();
        n_tests++;
        if (rxq.size() !== 100 || tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_reach100 got len=%0d valid=%b want 100 1", rxq.size(), tx_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        outs = {tx_valid, busy, debug_step, debug_en, frame_done, debug_addr, tx_data, 2'b00};
        n_tests++;
        if (outs !== 23'd0) begin
            n_fail++; $display("FAIL rstmid_outputs got=%h want=000000", outs);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        tick(); tick();
        model_frames(1);
        clear_mon();
        start = 1'b1; tick(); start = 1'b0;
        while (fd_cnt < 1 && cyc < 3000) tick();
        n_tests++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL rstmid_frame_done got=%0d want=1", fd_cnt); end
        n_tests++;
        if (rxq.size() < 1 || rxq[0] !== 8'hA5) begin
            n_fail++; $display("FAIL rstmid_header got=%h want=a5", (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        mism = 0;
        for (int i = 0; i < rxq.size() && i < expq.size(); i++) if (rxq[i] !== expq[i]) mism++;
        n_tests++;
        if (mism != 0 || rxq.size() != expq.size()) begin
            n_fail++; $display("FAIL rstmid_sequence got mismatches=%0d len=%0d want 0 len=%0d", mism, rxq.size(), expq.size());
        end
    endtask

    initial begin
        rst = 1'b1; run_mode = 1'b1; step_req = 1'b0; start = 1'b0; tx_ready = 1'b1;
        fill_random();
        #1;
        test_reset();
        test_frame_basic();
        test_frame_random_ready();
        test_step();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
